// File: rtl/pong_pkg.sv
// pong_pkg: shared state encoding, winner codes and colour width for the Pong game flow.
package pong_pkg;
  localparam int RGB_W = 12;
  typedef enum logic [2:0] {
    MENU  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    PAUSE = 3'd3,
    OVER  = 3'd4
  } state_t;
  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
endpackage

// File: rtl/game_fsm_frame_counter.sv
// frame_counter: loadable frame down-counter; done flags the tick that takes it from 1 to 0.
module frame_counter #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done
);
  logic [W-1:0] count;
  always_ff @(posedge clk)
    if (reset) count <= '0;
    else if (load) count <= value;
    else if (tick && count != '0) count <= count - 1'b1;
  assign done = tick && count == W'(1);
endmodule

// File: rtl/game_fsm.sv
// game_fsm: Pong game-flow controller (menu, serve, play, pause, over) with scores and VGA source select.
// Build option PONG_PAUSE_EN compiles in the PAUSE state and pause_btn handling.
module game_fsm
  import pong_pkg::*;
#(
  parameter int WIN_SCORE    = 7,
  parameter int SCORE_W      = 4,
  parameter int SERVE_FRAMES = 120,
  parameter int OVER_FRAMES  = 300
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               single,
  input  logic               multi,
  input  logic               pause_btn,
  input  logic               point_p1,
  input  logic               point_p2,
  input  logic [RGB_W-1:0]   menu_rgb,
  input  logic [RGB_W-1:0]   game_rgb,
  output logic [RGB_W-1:0]   rgb_out,
  output logic               menu_active,
  output logic               ai_enable,
  output logic               game_run,
  output logic               ball_serve,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2,
  output logic [1:0]         winner
);
  localparam int MAXF = SERVE_FRAMES > OVER_FRAMES ? SERVE_FRAMES : OVER_FRAMES;
  localparam int CW = $clog2(MAXF + 1);
  state_t state, state_n;
  logic [SCORE_W-1:0] s1_n, s2_n, inc1, inc2;
  logic [1:0] win_n;
  logic ai_n, serve_n, load, done;
  logic [CW-1:0] value;
  assign inc1 = score_p1 + 1'b1;
  assign inc2 = score_p2 + 1'b1;
`ifndef PONG_PAUSE_EN
  logic unused_pause;
  assign unused_pause = pause_btn;
`endif
  frame_counter #(.W(CW)) u_cnt (
    .clk(clk),
    .reset(reset),
    .tick(frame_tick),
    .load(load),
    .value(value),
    .done(done)
  );
  always_comb begin
    state_n = state;
    s1_n = score_p1;
    s2_n = score_p2;
    win_n = winner;
    ai_n = ai_enable;
    serve_n = 1'b0;
    load = 1'b0;
    value = CW'(SERVE_FRAMES);
    case (state)
      MENU:
        if (single || multi) begin
          ai_n = single;
          s1_n = '0;
          s2_n = '0;
          win_n = WIN_NONE;
          load = 1'b1;
          state_n = SERVE;
        end
      SERVE:
        if (done) begin
          serve_n = 1'b1;
          state_n = PLAY;
        end
      PLAY:
        if (point_p1 && point_p2) begin
          load = 1'b1;
          state_n = SERVE;
        end else if (point_p1) begin
          s1_n = inc1;
          load = 1'b1;
          win_n = inc1 == SCORE_W'(WIN_SCORE) ? WIN_P1 : winner;
          value = inc1 == SCORE_W'(WIN_SCORE) ? CW'(OVER_FRAMES) : CW'(SERVE_FRAMES);
          state_n = inc1 == SCORE_W'(WIN_SCORE) ? OVER : SERVE;
        end else if (point_p2) begin
          s2_n = inc2;
          load = 1'b1;
          win_n = inc2 == SCORE_W'(WIN_SCORE) ? WIN_P2 : winner;
          value = inc2 == SCORE_W'(WIN_SCORE) ? CW'(OVER_FRAMES) : CW'(SERVE_FRAMES);
          state_n = inc2 == SCORE_W'(WIN_SCORE) ? OVER : SERVE;
        end
`ifdef PONG_PAUSE_EN
        else if (pause_btn) state_n = PAUSE;
      PAUSE: state_n = pause_btn ? PLAY : PAUSE;
`endif
      OVER: state_n = done ? MENU : OVER;
      default: state_n = MENU;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= MENU;
      rgb_out <= '0;
      menu_active <= 1'b1;
      ai_enable <= 1'b0;
      game_run <= 1'b0;
      ball_serve <= 1'b0;
      score_p1 <= '0;
      score_p2 <= '0;
      winner <= WIN_NONE;
    end else begin
      state <= state_n;
      rgb_out <= state == MENU ? menu_rgb : game_rgb;
      menu_active <= state_n == MENU;
      ai_enable <= ai_n;
      game_run <= state_n == PLAY;
      ball_serve <= serve_n;
      score_p1 <= s1_n;
      score_p2 <= s2_n;
      winner <= win_n;
    end
endmodule
